uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter with an integrated transmit FIFO, successor to the fixed 8N1 transmitter used on the SDIO-to-UART bridge. Data width, FIFO depth and divider width are generic. Stop-bit count is selected at run time, and a line-break generator is included. Parity generation is compiled in with a macro. The block sits between the bridge's byte/word producer and the UART TXD pin.

## Interface
- DATA_W, 8: data bits per frame; legal range 5..9.
- FIFO_DEPTH, 16: transmit FIFO entries; power of two, at least 2.
- DIV_W, 16: width of the bit-period divider.
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- dat  in  DATA_W  write data; LSB is transmitted first.
- txen  in  1  write strobe, active high; pushes `dat` on each cycle it is high.
- divp  in  DIV_W  bit period is divp+1 clk cycles; latched at frame start.
- stop2  in  1  1 selects two stop bits, 0 selects one; latched at frame start.
- par_mode  in  2  parity mode: 00 none, 01 odd, 10 even, 11 none. Ignored without the parity macro.
- brk  in  1  break request, level-sensitive.
- txd  out  1  serial output, idle high; reset value 1.
- txfull  out  1  FIFO full, active high; reset value 0.
- txempty  out  1  FIFO empty, active high; reset value 1.
- busy  out  1  high in any state other than IDLE; reset value 0.
- ovf  out  1  one-cycle pulse when a write is dropped; reset value 0.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy; reset value 0.

## Operation
- FIFO push: on txen=1 and txfull=0.
  - txen=1 while txfull=1: write dropped, contents unchanged, ovf=1 on the next cycle.
  - txfull is evaluated before any same-cycle pop, so a write to a full FIFO is dropped even if a pop happens in that cycle.
- Simultaneous push and pop on a non-full FIFO: both occur; level is unchanged.
- Pointers wrap modulo FIFO_DEPTH. level counts 0..FIFO_DEPTH.
- State machine: IDLE, START, DATA, PARITY, STOP, BREAK, MARK.
- IDLE:
  - txd=1.
  - If brk=1, go to BREAK. brk has priority over a non-empty FIFO.
  - Otherwise, if txempty=0: pop one word into the shift register, latch divp, stop2 and par_mode, clear the divider, go to START.
- START: txd=0 for one bit period, then go to DATA.
- DATA:
  - Shift out DATA_W bits, LSB first, one bit period each.
  - The bit counter runs 0..DATA_W-1.
  - Parity accumulates over the transmitted bits.
  - Next state is PARITY if parity is enabled and the mode is 01 or 10; otherwise STOP.
- PARITY: one bit period.
  - Even mode: txd = XOR of the data bits.
  - Odd mode: txd = inverted XOR of the data bits.
- STOP:
  - txd=1 for one bit period, or two if stop2 was latched as 1.
  - Then return to IDLE, which allows back-to-back frames with no extra idle bit.
- BREAK: txd=0 while brk=1. When brk falls, latch divp and go to MARK.
- MARK: txd=1 for one bit period, then go to IDLE.
- brk asserted mid-frame has no effect until the frame completes.
- Divider counts 0..divp.
  - At divp: reset to 0 and advance the bit or state.
  - divp=0 gives one bit per clk cycle.
  - Changing divp, stop2 or par_mode mid-frame has no effect until the next frame.

## Timing
- txd is a registered output, glitch-free.
- Latency from write to start bit, with the block idle and the FIFO empty:
  - write accepted at edge N;
  - txempty=0 after edge N;
  - IDLE pops at edge N+1;
  - txd=0 from edge N+2.
- Every bit, including start, parity and stop bits, lasts exactly divp+1 cycles.
- Frame length is (1 + DATA_W + P + S)·(divp+1) cycles, where P is 0 or 1 (parity bit) and S is 1 or 2 (stop bits).
- busy rises one cycle after the pop decision and falls on the edge that enters IDLE.
- Reset asserted mid-operation:
  - txd=1 immediately (asynchronous);
  - FIFO is emptied and state returns to IDLE;
  - no partial frame resumes after reset.

## Configuration
- UART_TX_PARITY_EN
  - Defined: par_mode is honoured and the PARITY state exists.
  - Undefined: par_mode is ignored, the PARITY state and parity accumulator are removed, and frames are always N-1 or N-2 (no parity).

## Structure
- Package uart_pkg holds:
  - the state enum, tx_state_t;
  - the par_mode encodings PAR_NONE, PAR_ODD and PAR_EVEN.
- Sub-module uart_fifo_sync: the parameterised synchronous FIFO, exposing push/pop, full/empty and level. It is reusable for the future RX path.

## Test plan
- Write 0x55 with divp=3, DATA_W=8, no parity, stop2=0 -> txd low from write+2, then 1,0,1,0,1,0,1,0, then a stop bit, each bit 4 cycles; 40 cycles total.
- Write 0x07 with even parity, then 0x07 with odd parity, divp=1 -> parity bit is 1 then 0; frames 11 bits × 2 cycles each.
- Write 17 words into a 16-deep FIFO in consecutive cycles with divp=100 -> 16 words accepted, ovf pulses once, txfull=1 until the first pop, and all 16 frames are transmitted in order.
- Hold brk=1 while idle with divp=9 -> txd=0 for the whole brk duration, then txd=1 for 10 cycles of MARK; a queued word 0xA5 starts only after MARK.
- Assert rst mid-DATA with 3 words queued -> txd=1 immediately, txempty=1, level=0, busy=0; no frame follows the release of rst.
- stop2=1 with DATA_W=5 and divp=0, streaming 0x1F, 0x00 -> 8-cycle frames back-to-back; stop bits occupy 2 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types for the UART transmit path.
//   tx_state_t  : transmitter FSM states (ST_PARITY only exists when
//                 UART_TX_PARITY_EN is defined)
//   PAR_*       : par_mode encodings (2'b11 is treated as "none")
//   par_enabled : 1 when a par_mode value requests a parity bit
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5,
    ST_MARK   = 3'd6
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// -----------------------------------------------------------------------------
// uart_tx_param_if
// Producer-side bundle of the UART transmitter.
//   master (producer): drives dat, txen, divp, stop2, par_mode, brk
//   slave  (uart_tx_param): drives txd, txfull, txempty, busy, ovf, level,
//                           dbg_state
// Handshake: txen is a push strobe, not a request/grant pair. A word on dat is
// accepted on every rising clk edge where txen=1 and txfull=0 (txfull as it
// stood before that edge). A strobe while txfull=1 is dropped and reported by
// a one-cycle ovf pulse after the edge.
// dbg_state mirrors the transmitter FSM state register.
// -----------------------------------------------------------------------------
interface uart_tx_param_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
);
  import uart_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] dat;
  logic              txen;
  logic [DIV_W-1:0]  divp;
  logic              stop2;
  logic [1:0]        par_mode;
  logic              brk;

  logic              txd;
  logic              txfull;
  logic              txempty;
  logic              busy;
  logic              ovf;
  logic [LVL_W-1:0]  level;
  tx_state_t         dbg_state;

  modport master (
    output dat, txen, divp, stop2, par_mode, brk,
    input  txd, txfull, txempty, busy, ovf, level, dbg_state
  );

  modport slave (
    input  dat, txen, divp, stop2, par_mode, brk,
    output txd, txfull, txempty, busy, ovf, level, dbg_state
  );

endinterface

// File: rtl/uart_fifo_sync.sv
// -----------------------------------------------------------------------------
// uart_fifo_sync
// Single-clock FIFO with first-word fall-through read data.
//   clk, rst  : clock, asynchronous active-low reset
//   i_push    : write strobe (ignored while full)
//   i_din     : write data
//   i_pop     : read strobe (ignored while empty)
//   o_dout    : head-of-queue word, valid while o_empty=0
//   o_full    : DEPTH entries held
//   o_empty   : no entries held
//   o_ovf     : one-cycle pulse after a push that was dropped
//   o_level   : occupancy 0..DEPTH
// DEPTH must be a power of two (pointers wrap naturally).
// -----------------------------------------------------------------------------
module uart_fifo_sync #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_din,
  input  logic                   i_pop,
  output logic [W-1:0]           o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_ovf,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic          r_ovf;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  // Full is the registered occupancy, so a write to a full FIFO is dropped
  // even when a pop frees a slot on the same edge.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd];
  assign o_ovf   = r_ovf;
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= i_push && o_full;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter with integrated transmit FIFO and line-break
// generator.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : uart_tx_param_if.slave (dat/txen push, divp, stop2, par_mode,
//              brk in; txd, txfull, txempty, busy, ovf, level, dbg_state out)
// Parameters DATA_W (5..9), FIFO_DEPTH (power of two >= 2) and DIV_W must
// match the connected interface instance.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state and honours
// par_mode; without it frames carry no parity bit.
// txd is registered from the current state, so the line lags the state
// register by one cycle.
// -----------------------------------------------------------------------------
module uart_tx_param import uart_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_param_if.slave bus
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_t         r_state;
  logic              r_txd;
  logic              r_busy;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_divp;
  logic              r_stop2;
  logic              r_stop_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [BIT_W-1:0]  r_bit;
`ifdef UART_TX_PARITY_EN
  logic              r_par;
  logic [1:0]        r_par_mode;
`else
  logic              w_unused_par;
  assign w_unused_par = ^bus.par_mode;
`endif

  logic [DATA_W-1:0] w_fifo_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_ovf;
  logic [LVL_W-1:0]  w_level;
  logic              w_tick;
  logic [DIV_W-1:0]  w_div_next;
  logic              w_last_bit;
  logic              w_last_stop;
  logic              w_start_frame;
  logic              w_line;

  uart_fifo_sync #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.txen),
    .i_din   (bus.dat),
    .i_pop   (w_start_frame),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_ovf   (w_ovf),
    .o_level (w_level)
  );

  assign w_tick      = (r_div == r_divp);
  assign w_div_next  = w_tick ? '0 : r_div + 1'b1;
  assign w_last_bit  = (r_bit == BIT_W'(DATA_W - 1));
  assign w_last_stop = !r_stop2 || r_stop_cnt;

  // The IDLE pop decision is also taken in the last cycle of the final stop
  // bit; otherwise the one-cycle txd lag would insert an idle cycle between
  // queued frames. A pending break still routes through IDLE.
  assign w_start_frame = !bus.brk && !w_empty &&
                         ((r_state == ST_IDLE) ||
                          ((r_state == ST_STOP) && w_tick && w_last_stop));

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      ST_START, ST_BREAK: w_line = 1'b0;
      ST_DATA:            w_line = r_shift[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY:          w_line = (r_par_mode == PAR_EVEN) ? r_par : ~r_par;
`endif
      default:            w_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_div      <= '0;
      r_divp     <= '0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_bit      <= '0;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
      r_par_mode <= PAR_NONE;
`endif
    end else begin
      r_txd <= w_line;
      if (w_start_frame) begin
        // Frame configuration is frozen here for the whole frame.
        r_shift <= w_fifo_dout;
        r_divp  <= bus.divp;
        r_stop2 <= bus.stop2;
        r_div   <= '0;
        r_state <= ST_START;
        r_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
        r_par      <= 1'b0;
        r_par_mode <= bus.par_mode;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.brk) begin
              r_state <= ST_BREAK;
              r_busy  <= 1'b1;
            end
          end
          ST_START: begin
            r_div <= w_div_next;
            if (w_tick) begin
              r_bit   <= '0;
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            r_div <= w_div_next;
            if (w_tick) begin
              r_shift <= r_shift >> 1;
`ifdef UART_TX_PARITY_EN
              r_par   <= r_par ^ r_shift[0];
`endif
              if (w_last_bit) begin
                r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
                r_state    <= par_enabled(r_par_mode) ? ST_PARITY : ST_STOP;
`else
                r_state    <= ST_STOP;
`endif
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            r_div <= w_div_next;
            if (w_tick) r_state <= ST_STOP;
          end
`endif
          ST_STOP: begin
            r_div <= w_div_next;
            if (w_tick) begin
              if (!w_last_stop) begin
                r_stop_cnt <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          ST_BREAK: begin
            if (!bus.brk) begin
              r_divp  <= bus.divp;
              r_div   <= '0;
              r_state <= ST_MARK;
            end
          end
          ST_MARK: begin
            r_div <= w_div_next;
            if (w_tick) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.txd       = r_txd;
  assign bus.busy      = r_busy;
  assign bus.txfull    = w_full;
  assign bus.txempty   = w_empty;
  assign bus.ovf       = w_ovf;
  assign bus.level     = w_level;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
// Directed bench for uart_tx_param. Two instances share clk/rst: an 8-bit,
// 16-deep transmitter and a 5-bit, 4-deep one for the short-frame case.
// Inputs are driven 1 ns after a rising edge; outputs are sampled at the same
// point, so a sample taken after edge k shows the state produced by edge k.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_param;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) u_if ();
  uart_tx_param_if #(.DATA_W(5), .FIFO_DEPTH(4),  .DIV_W(8))  u_if5 ();

  uart_tx_param #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  uart_tx_param #(.DATA_W(5), .FIFO_DEPTH(4), .DIV_W(8)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (u_if5)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard of words expected on the 8-bit line
  logic [7:0] exp_q[$];

  // ---------------- driver / utility tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] d);
    u_if.dat  = d;
    u_if.txen = 1'b1;
    tick();
    u_if.txen = 1'b0;
  endtask

  // Record txd for n cycles; index 0 is the sample after the next edge.
  task automatic capture(input int which, input int n, output logic [127:0] v);
    v = '1;
    for (int i = 0; i < n; i++) begin
      tick();
      v[i] = (which == 0) ? u_if.txd : u_if5.txd;
    end
  endtask

  // Reference frame builder: start, data LSB first, optional parity
  // (1 = odd, 2 = even), stop bits; every bit is divp+1 cycles.
  task automatic add_frame(inout logic [127:0] v, inout int pos,
                           input int data, input int dw, input int divp,
                           input int par, input int stops);
    logic [15:0] dv;
    logic        p;
    dv = 16'(data);
    p  = ^dv;
    for (int k = 0; k <= divp; k++) begin v[pos] = 1'b0; pos++; end
    for (int b = 0; b < dw; b++)
      for (int k = 0; k <= divp; k++) begin v[pos] = dv[b]; pos++; end
    if (par != 0)
      for (int k = 0; k <= divp; k++) begin v[pos] = (par == 2) ? p : ~p; pos++; end
    for (int k = 0; k < stops * (divp + 1); k++) begin v[pos] = 1'b1; pos++; end
  endtask

  // Mid-bit sampling receiver for the 8-bit line; ok=0 if no start bit shows.
  task automatic rx8(input int divp, output logic [7:0] d, output bit ok);
    int w;
    ok = 1'b1;
    d  = '0;
    w  = 0;
    while (u_if.txd !== 1'b0 && w < 2000) begin tick(); w++; end
    if (u_if.txd !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int k = 0; k < divp / 2; k++) tick();
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k <= divp; k++) tick();
      d[b] = u_if.txd;
    end
    for (int k = 0; k <= divp; k++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_tests++; if (u_if.txd !== 1'b1) begin n_fail++; $display("FAIL rst_txd: got %b want 1", u_if.txd); end
    n_tests++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", u_if.busy); end
    rst = 1'b1;
    tick();
    n_tests++; if (u_if.txfull !== 1'b0) begin n_fail++; $display("FAIL rst_txfull: got %b want 0", u_if.txfull); end
    n_tests++; if (u_if.txempty !== 1'b1) begin n_fail++; $display("FAIL rst_txempty: got %b want 1", u_if.txempty); end
    n_tests++; if (u_if.ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", u_if.ovf); end
    n_tests++; if (u_if.level !== 5'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", u_if.level); end
    n_tests++; if (u_if.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", u_if.dbg_state, ST_IDLE); end
    n_tests++; if (u_if5.txd !== 1'b1) begin n_fail++; $display("FAIL rst_txd5: got %b want 1", u_if5.txd); end
  endtask

  task automatic test_basic_55();
    logic [127:0] obs, exp;
    int pos;
    u_if.divp = 16'd3; u_if.stop2 = 1'b0; u_if.par_mode = PAR_NONE;
    send8(8'h55);                      // accepted at edge N
    n_tests++; if (u_if.level !== 5'd1) begin n_fail++; $display("FAIL basic_level: got %0d want 1", u_if.level); end
    n_tests++; if (u_if.txempty !== 1'b0) begin n_fail++; $display("FAIL basic_txempty: got %b want 0", u_if.txempty); end
    tick();                            // edge N+1: pop
    n_tests++; if (u_if.txd !== 1'b1) begin n_fail++; $display("FAIL basic_txd_n1: got %b want 1", u_if.txd); end
    n_tests++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", u_if.busy); end
    capture(0, 44, obs);               // edges N+2 .. N+45
    exp = '1; pos = 0;
    add_frame(exp, pos, 8'h55, 8, 3, 0, 1);
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL basic_frame: got %h want %h", obs, exp); end
    n_tests++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", u_if.busy); end
  endtask

  task automatic test_parity();
    logic [127:0] obs, exp;
    int pos;
    u_if.divp = 16'd1;
`ifdef UART_TX_PARITY_EN
    u_if.par_mode = PAR_EVEN;
    send8(8'h07); tick();
    capture(0, 24, obs);
    exp = '1; pos = 0;
    add_frame(exp, pos, 8'h07, 8, 1, 2, 1);
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL par_even_frame: got %h want %h", obs, exp); end
    n_tests++; if (obs[18] !== 1'b1) begin n_fail++; $display("FAIL par_even_bit: got %b want 1", obs[18]); end
    u_if.par_mode = PAR_ODD;
    send8(8'h07); tick();
    capture(0, 24, obs);
    exp = '1; pos = 0;
    add_frame(exp, pos, 8'h07, 8, 1, 1, 1);
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL par_odd_frame: got %h want %h", obs, exp); end
    n_tests++; if (obs[18] !== 1'b0) begin n_fail++; $display("FAIL par_odd_bit: got %b want 0", obs[18]); end
`else
    // par_mode has no effect in this build: a plain 10-bit frame follows.
    u_if.par_mode = PAR_EVEN;
    send8(8'h07); tick();
    capture(0, 24, obs);
    exp = '1; pos = 0;
    add_frame(exp, pos, 8'h07, 8, 1, 0, 1);
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL nopar_frame: got %h want %h", obs, exp); end
    n_tests++; if (obs[18] !== 1'b1) begin n_fail++; $display("FAIL nopar_stop: got %b want 1", obs[18]); end
`endif
    u_if.par_mode = PAR_NONE;
  endtask

  task automatic test_overflow();
    int occ, k;
    logic [7:0] d;
    bit ok;
    u_if.divp = 16'd100; u_if.stop2 = 1'b0;
    exp_q.delete();
    send8(8'hFF);                      // lead frame, popped at N+1
    tick();
    occ = 0;
    for (int i = 0; i < 17; i++) begin // writes at N+2 .. N+18
      u_if.dat  = 8'(8'h30 + i);
      u_if.txen = 1'b1;
      if (occ < 16) begin exp_q.push_back(8'(8'h30 + i)); occ++; end
      tick();
      if (i == 15) begin
        n_tests++; if (u_if.txfull !== 1'b1) begin n_fail++; $display("FAIL ovf_full_set: got %b want 1", u_if.txfull); end
        n_tests++; if (u_if.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", u_if.ovf); end
      end
    end
    u_if.txen = 1'b0;
    n_tests++; if (u_if.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", u_if.ovf); end
    n_tests++; if (u_if.level !== 5'd16) begin n_fail++; $display("FAIL ovf_level: got %0d want 16", u_if.level); end
    tick();
    n_tests++; if (u_if.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle: got %b want 0", u_if.ovf); end
    // lead frame occupies 10*101 cycles from N+1; first queued pop at N+1011
    k = 0;
    while (u_if.txfull === 1'b1 && k < 2000) begin tick(); k++; end
    n_tests++; if (k !== 992) begin n_fail++; $display("FAIL ovf_full_hold: got %0d cycles want 992", k); end
    n_tests++; if (u_if.level !== 5'd15) begin n_fail++; $display("FAIL ovf_level_pop: got %0d want 15", u_if.level); end
    for (int f = 0; f < 16; f++) begin
      rx8(100, d, ok);
      n_tests++;
      if (!ok) begin
        n_fail++; $display("FAIL ovf_rx_timeout: frame %0d", f);
      end else if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL ovf_rx_extra: got %h want none", d);
      end else if (d !== exp_q[0]) begin
        n_fail++; $display("FAIL ovf_rx_data: frame %0d got %h want %h", f, d, exp_q[0]);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    n_tests++; if (u_if.txempty !== 1'b1) begin n_fail++; $display("FAIL ovf_drain: txempty got %b want 1", u_if.txempty); end
    repeat (120) tick();
  endtask

  task automatic test_break();
    logic [127:0] obs;
    logic [7:0] d;
    bit ok;
    int low_bad;
    u_if.divp = 16'd9;
    u_if.brk  = 1'b1;                  // set after edge E0
    tick();
    n_tests++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL brk_busy: got %b want 1", u_if.busy); end
    tick();                            // E0+2: line low
    u_if.dat = 8'hA5; u_if.txen = 1'b1;
    low_bad = 0;
    for (int i = 0; i < 18; i++) begin
      if (u_if.txd !== 1'b0) low_bad++;
      tick();
      if (i == 0) u_if.txen = 1'b0;
    end
    n_tests++; if (u_if.level !== 5'd1) begin n_fail++; $display("FAIL brk_hold_queue: level got %0d want 1", u_if.level); end
    u_if.brk = 1'b0;                   // falls after E1
    tick();
    if (u_if.txd !== 1'b0) low_bad++;
    n_tests++; if (low_bad !== 0) begin n_fail++; $display("FAIL brk_low: %0d cycles high want 0", low_bad); end
    capture(0, 11, obs);               // 10 MARK cycles + 1 IDLE cycle
    n_tests++; if (obs !== '1) begin n_fail++; $display("FAIL brk_mark: got %h want all ones", obs); end
    tick();
    n_tests++; if (u_if.txd !== 1'b0) begin n_fail++; $display("FAIL brk_start: got %b want 0", u_if.txd); end
    rx8(9, d, ok);
    n_tests++; if (!ok || d !== 8'hA5) begin n_fail++; $display("FAIL brk_word: got %h ok %0d want a5", d, ok); end
    repeat (30) tick();
  endtask

  task automatic test_reset_mid();
    int bad;
    u_if.divp = 16'd3;
    for (int i = 0; i < 4; i++) begin
      u_if.dat = 8'h00; u_if.txen = 1'b1;
      tick();
    end
    u_if.txen = 1'b0;
    repeat (9) tick();                 // in DATA, line low
    n_tests++; if (u_if.level !== 5'd3) begin n_fail++; $display("FAIL rmid_level_pre: got %0d want 3", u_if.level); end
    n_tests++; if (u_if.txd !== 1'b0) begin n_fail++; $display("FAIL rmid_txd_pre: got %b want 0", u_if.txd); end
    rst = 1'b0;
    #1;
    n_tests++; if (u_if.txd !== 1'b1) begin n_fail++; $display("FAIL rmid_txd: got %b want 1", u_if.txd); end
    n_tests++; if (u_if.txempty !== 1'b1) begin n_fail++; $display("FAIL rmid_txempty: got %b want 1", u_if.txempty); end
    n_tests++; if (u_if.level !== 5'd0) begin n_fail++; $display("FAIL rmid_level: got %0d want 0", u_if.level); end
    n_tests++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", u_if.busy); end
    repeat (3) tick();
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (u_if.txd !== 1'b1 || u_if.busy !== 1'b0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_no_resume: %0d active cycles want 0", bad); end
  endtask

  task automatic test_stop2_dw5();
    logic [127:0] obs, exp;
    int pos;
    u_if5.divp = 8'd0; u_if5.stop2 = 1'b1; u_if5.par_mode = PAR_NONE;
    u_if5.dat = 5'h1F; u_if5.txen = 1'b1;
    tick();                            // edge N
    u_if5.dat = 5'h00;
    tick();                            // edge N+1
    u_if5.txen = 1'b0;
    n_tests++; if (u_if5.busy !== 1'b1) begin n_fail++; $display("FAIL dw5_busy: got %b want 1", u_if5.busy); end
    capture(1, 20, obs);
    exp = '1; pos = 0;
    add_frame(exp, pos, 5'h1F, 5, 0, 0, 2);
    add_frame(exp, pos, 5'h00, 5, 0, 0, 2);
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL dw5_frames: got %h want %h", obs, exp); end
    n_tests++; if (u_if5.busy !== 1'b0) begin n_fail++; $display("FAIL dw5_busy_end: got %b want 0", u_if5.busy); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    u_if.dat = '0;  u_if.txen = 1'b0;  u_if.divp = '0;  u_if.stop2 = 1'b0;
    u_if.par_mode = PAR_NONE;  u_if.brk = 1'b0;
    u_if5.dat = '0; u_if5.txen = 1'b0; u_if5.divp = '0; u_if5.stop2 = 1'b0;
    u_if5.par_mode = PAR_NONE; u_if5.brk = 1'b0;
    rst = 1'b0;
    #2;
    test_reset();
    test_basic_55();
    test_parity();
    test_overflow();
    test_break();
    test_reset_mid();
    test_stop2_dw5();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
